// File: rtl/rv_reverse_delay_line.sv
// Chain of skid buffers that registers the ready path at every stage.
// Optional occupancy port: define RV_REVERSE_DELAY_LINE_OCCUPANCY_EN.
module rv_reverse_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 5
) (
    input  logic                          clock_port,
    input  logic                          reset_port,
    input  logic [DATA_WIDTH-1:0]         input_port_data,
    input  logic                          input_port_valid,
    output logic                          input_port_ready,
    output logic [DATA_WIDTH-1:0]         output_port_data,
    output logic                          output_port_valid,
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
    input  logic                          output_port_ready,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
`else
    input  logic                          output_port_ready
`endif
);

    // Index k is the input side of stage k; index STAGES is the output side.
    logic [STAGES:0]          link_valid;
    logic [STAGES:0]          link_ready;
    logic [DATA_WIDTH-1:0]    link_data [STAGES+1];

    logic [STAGES-1:0]        skid_valid;
    logic [DATA_WIDTH-1:0]    skid_data [STAGES];

    assign link_valid[0]      = input_port_valid;
    assign link_data[0]       = input_port_data;
    assign link_ready[STAGES] = output_port_ready;

    assign input_port_ready  = link_ready[0];
    assign output_port_valid = link_valid[STAGES];
    assign output_port_data  = link_data[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign link_ready[k]   = ~skid_valid[k];
        assign link_valid[k+1] = skid_valid[k] | link_valid[k];
        assign link_data[k+1]  = skid_valid[k] ? skid_data[k] : link_data[k];

        always_ff @(posedge clock_port or negedge reset_port) begin
            if (!reset_port) begin
                skid_valid[k] <= 1'b0;
                skid_data[k]  <= '0;
            end else if (link_valid[k] & link_ready[k] & ~link_ready[k+1]) begin
                skid_valid[k] <= 1'b1;
                skid_data[k]  <= link_data[k];
            end else if (skid_valid[k] & link_ready[k+1]) begin
                skid_valid[k] <= 1'b0;
            end
        end
    end

`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
    localparam int OCC_W = $clog2(STAGES+1);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(skid_valid[i]);
        end
    end
`endif

endmodule

// File: tb/tb_rv_reverse_delay_line.sv
// Scoreboard bench for rv_reverse_delay_line (STAGES=5, DATA_WIDTH=8).
// Occupancy checks are active when RV_REVERSE_DELAY_LINE_OCCUPANCY_EN is defined.
module tb_rv_reverse_delay_line;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
    logic [2:0] occ;
`endif

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    int occ_max = 0;
    bit track_occ = 0;
    logic [7:0] exp_q [$];

    rv_reverse_delay_line #(.DATA_WIDTH(8), .STAGES(5)) dut (
        .clock_port       (clk),
        .reset_port       (rst_n),
        .input_port_data  (in_data),
        .input_port_valid (in_valid),
        .input_port_ready (in_ready),
        .output_port_data (out_data),
        .output_port_valid(out_valid),
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
        .output_port_ready(out_ready),
        .occupancy        (occ)
`else
        .output_port_ready(out_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_occ(input string name, input int req);
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
        chk(name, 32'(occ), req);
`endif
    endtask

    // Drive one cycle's inputs just after the edge; record accepted beats.
    task automatic step(input bit v, input logic [7:0] d, input bit ordy,
                        output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #2;
        acc = v && in_ready;
        if (acc) exp_q.push_back(d);
    endtask

    // Monitor: every downstream transfer pops and compares.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual %0h required none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
        if (track_occ && int'(occ) > occ_max) occ_max = int'(occ);
`endif
    end

    initial begin
        bit acc;
        int sent;
        int guard;
        int cyc;
        int iso_acc;
        logic r0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state: stream passes straight through, ready high.
        #1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 1);
        chk("rst_out_data", 32'(out_data), 32'hA5);
        chk_occ("rst_occ", 0);
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid0", 32'(out_valid), 0);
        rst_n = 1'b1;

        // Pass-through with zero latency.
        step(1, 8'h11, 1, acc);
        chk("pt_out_data0", 32'(out_data), 32'h11);
        chk("pt_in_ready0", 32'(in_ready), 1);
        chk_occ("pt_occ0", 0);
        step(1, 8'h22, 1, acc);
        chk("pt_out_data1", 32'(out_data), 32'h22);
        chk("pt_in_ready1", 32'(in_ready), 1);
        chk_occ("pt_occ1", 0);
        step(1, 8'h33, 1, acc);
        chk("pt_out_data2", 32'(out_data), 32'h33);
        chk("pt_in_ready2", 32'(in_ready), 1);
        chk_occ("pt_occ2", 0);

        // Fill: exactly five beats accepted under backpressure.
        for (int i = 1; i <= 7; i++) begin
            step(1, 8'(i), 0, acc);
            chk("fill_acc", 32'(acc), 32'(i <= 5));
        end
        step(0, 8'h00, 0, acc);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_out_data", 32'(out_data), 32'h01);
        chk_occ("full_occ", 5);

        // Drain in order, one beat per cycle.
        for (int i = 1; i <= 5; i++) begin
            step(0, 8'h00, 1, acc);
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_data", 32'(out_data), 32'(i));
        end
        step(0, 8'h00, 1, acc);
        chk("drained_valid", 32'(out_valid), 0);
        chk("drained_in_ready", 32'(in_ready), 1);
        chk_occ("drained_occ", 0);

        // Full-rate stream with a one-cycle stall every 7 cycles.
        sent = 0;
        guard = 0;
        cyc = 0;
        track_occ = 1;
        occ_max = 0;
        while (sent < 256 && guard < 1000) begin
            step(1, sent[7:0], (cyc % 7) != 6, acc);
            if (acc) sent++;
            cyc++;
            guard++;
        end
        chk("stream_sent", 32'(sent), 256);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, acc);
        track_occ = 0;
`ifdef RV_REVERSE_DELAY_LINE_OCCUPANCY_EN
        chk("stream_occ_max_le1", 32'(occ_max <= 1), 1);
`endif
        chk("stream_q_empty", 32'(exp_q.size()), 0);

        // Ready isolation: toggling downstream ready within a cycle.
        iso_acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            r0 = in_ready;
            if (r0) begin
                exp_q.push_back(in_data);
                iso_acc++;
            end
            for (int j = 0; j < 3; j++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                chk("iso_in_ready", 32'(in_ready), 32'(r0));
            end
        end
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, acc);
        chk("iso_q_empty", 32'(exp_q.size()), 0);

        // Async reset with three beats buffered.
        step(1, 8'hA1, 0, acc);
        step(1, 8'hA2, 0, acc);
        step(1, 8'hA3, 0, acc);
        step(0, 8'h00, 0, acc);
        chk("pre_rst_out_data", 32'(out_data), 32'hA1);
        chk_occ("pre_rst_occ", 3);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_valid0", 32'(out_valid), 0);
        chk_occ("arst_occ", 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        chk("arst_out_valid1", 32'(out_valid), 1);
        chk("arst_out_data", 32'(out_data), 32'h5A);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, acc);
            chk("post_rst_valid", 32'(out_valid), 0);
        end

        chk("final_q_empty", 32'(exp_q.size()), 0);
        chk("rx_total", 32'(rx_count), 32'(3 + 5 + 256 + iso_acc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
